// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed hex display for a 32-bit value on a common-anode 7-segment bank.
// The shown value is swapped only at frame boundaries; digit 0 can flash a "new value" dp marker.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int NEW_FRAMES  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic [31:0] din,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int NW = $clog2(NEW_FRAMES + 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   hold;
  logic [31:0]   show;
  logic [NW-1:0] newcnt;

  logic          tick;
  logic          frame;
  logic          load_new;
  logic [2:0]    idx_nxt;
  logic [31:0]   show_nxt;
  logic [31:0]   upper;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick     = (cnt == CW'(REFRESH_DIV - 1));
  assign frame    = tick && (idx == 3'd7);
  assign load_new = upd && (din != hold);
  assign idx_nxt  = idx + 3'd1;
  // At a boundary the outputs already reflect the value entering show (including an upd bypass).
  assign show_nxt = frame ? (upd ? din : hold) : show;
  assign upper    = show_nxt >> {idx_nxt, 2'b00};
  assign blank    = blank_lz && (idx_nxt != 3'd0) && (upper == 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= 3'd7;
      hold   <= '0;
      show   <= '0;
      newcnt <= '0;
      an     <= 8'hFF;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (upd) hold <= din;
      // A fresh value reloads the marker even when a boundary decrement lands on the same edge.
      if (load_new)
        newcnt <= NW'(NEW_FRAMES);
      else if (frame && newcnt != '0)
        newcnt <= newcnt - NW'(1);
      if (tick) begin
        idx  <= idx_nxt;
        show <= show_nxt;
        dp   <= !((idx_nxt == 3'd0) && (newcnt != '0));
        if (blank) begin
          an  <= 8'hFF;
          seg <= 7'h7F;
        end else begin
          an  <= ~(8'b1 << idx_nxt);
          seg <= hex7(upper[3:0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: per-cycle reference model, directed frame tables and random traffic.
module tb_seg7_scan_driver;
  localparam int RD = 4;
  localparam int NF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic [31:0] din = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(.REFRESH_DIV(RD), .NEW_FRAMES(NF)) dut (
    .clk(clk), .rst(rst), .upd(upd), .din(din), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: time since reset in cycles, ticks counted as slots, frames as 8 slots.
  int          m_cyc, m_ticks, m_new, m_nidx;
  logic [31:0] m_hold, m_show;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  bit          m_tick, m_bnd;

  typedef struct {
    logic            blz;
    logic [31:0]     v;
    logic [7:0][6:0] segs;
    logic [7:0]      blk;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_step();
    bit          ld;
    logic [31:0] sn, up;
    if (rst) begin
      m_cyc = 0; m_ticks = 0; m_new = 0; m_hold = '0; m_show = '0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; m_tick = 0; m_bnd = 0;
    end else begin
      m_tick = ((m_cyc % RD) == RD - 1);
      m_cyc++;
      ld = upd && (din != m_hold);
      m_bnd = m_tick && ((m_ticks % 8) == 0);
      if (m_tick) begin
        m_nidx = m_ticks % 8;
        sn = m_bnd ? (upd ? din : m_hold) : m_show;
        up = sn >> (4 * m_nidx);
        if (blank_lz && m_nidx != 0 && up == 0) begin
          e_an = 8'hFF; e_seg = 7'h7F;
        end else begin
          e_an = 8'hFF ^ (8'h1 << m_nidx);
          e_seg = lut[up[3:0]];
        end
        e_dp = !(m_nidx == 0 && m_new != 0);
        m_show = sn;
        if (m_bnd && m_new > 0) m_new--;
        m_ticks++;
      end
      if (ld) m_new = NF;
      if (upd) m_hold = din;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("model", {an, seg, dp}, {e_an, e_seg, e_dp});
  endtask

  task automatic to_boundary(input string name);
    int g = 0;
    while (!m_bnd && g < 40) begin cycle(); g++; end
    if (!m_bnd) timeout(name);
  endtask

  task automatic run_entry(input int i);
    blank_lz = tbl[i].blz; din = tbl[i].v; upd = 1'b1;
    cycle();
    upd = 1'b0;
    to_boundary("entry_align");
    for (int k = 0; k < 8; k++) begin
      check($sformatf("tbl%0d_an%0d", i, k), an, tbl[i].blk[k] ? 8'hFF : (8'hFF ^ (8'h1 << k)));
      check($sformatf("tbl%0d_seg%0d", i, k), seg, tbl[i].segs[k]);
      if (k < 7) repeat (RD) cycle();
    end
  endtask

  initial begin
    int cnt0, g;
    tbl[0] = '{1'b0, 32'h1234ABCD,
               {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 8'h00};
    tbl[1] = '{1'b1, 32'h000000A5,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0001000, 7'b0010010}, 8'hFC};
    tbl[2] = '{1'b1, 32'h00000000,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 8'hFE};
    tbl[3] = '{1'b1, 32'h00F00001,
               {7'h7F, 7'h7F, 7'b0001110, 7'b1000000,
                7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001}, 8'hC0};

    // Reset held for three clocks, then the first slot appears on the fourth edge.
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_out", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    rst = 1'b0;
    for (int c = 0; c < RD - 1; c++) begin
      cycle();
      check("pre_tick_an", an, 8'hFF);
    end
    cycle();
    check("first_an", an, 8'hFE);
    check("first_seg", seg, 7'b1000000);
    for (int k = 1; k < 8; k++) begin
      repeat (RD) cycle();
      check($sformatf("scan_an%0d", k), an, 8'hFF ^ (8'h1 << k));
    end

    // Land the first update mid-frame at slot 3; the rest of that frame still shows 0.
    g = 0;
    while (!(m_tick && m_nidx == 3) && g < 40) begin cycle(); g++; end
    if (!(m_tick && m_nidx == 3)) timeout("idx3_align");
    for (int i = 0; i < 3; i++) run_entry(i);

    // New-value marker: two digit-0 slots with dp low, then none on a repeat of the same value.
    repeat (80) cycle();
    blank_lz = 1'b0; din = 32'h5; upd = 1'b1;
    cycle();
    upd = 1'b0;
    cnt0 = (dp == 1'b0);
    repeat (RD * 32 + 8) begin cycle(); if (dp == 1'b0) cnt0++; end
    check("new_marker_cycles", cnt0, 2 * RD);
    upd = 1'b1;
    cycle();
    upd = 1'b0;
    cnt0 = (dp == 1'b0);
    repeat (RD * 32 + 8) begin cycle(); if (dp == 1'b0) cnt0++; end
    check("same_value_no_marker", cnt0, 0);

    run_entry(3);

    // Update coincident with the frame-boundary tick bypasses straight into the display.
    blank_lz = 1'b0;
    g = 0;
    while (!((m_cyc % RD) == RD - 1 && (m_ticks % 8) == 0) && g < 40) begin cycle(); g++; end
    if (g >= 40) timeout("bnd_align");
    din = 32'hF; upd = 1'b1;
    cycle();
    upd = 1'b0;
    check("bypass_an", an, 8'hFE);
    check("bypass_seg", seg, 7'b0001110);

    // Reset mid-frame at slot 5 while showing all F.
    din = 32'hFFFFFFFF; upd = 1'b1;
    cycle();
    upd = 1'b0;
    to_boundary("ff_align");
    g = 0;
    while (!(m_tick && m_nidx == 5) && g < 40) begin cycle(); g++; end
    if (!(m_tick && m_nidx == 5)) timeout("idx5_align");
    check("ff_seg5", seg, 7'b0001110);
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_out", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    rst = 1'b0;
    repeat (RD - 1) cycle();
    check("midrst_hold_an", an, 8'hFF);
    cycle();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("zero_frame_an%0d", k), an, 8'hFF ^ (8'h1 << k));
      check($sformatf("zero_frame_seg%0d", k), seg, 7'b1000000);
      if (k < 7) repeat (RD) cycle();
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(499) == 0);
      upd = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0: din = $urandom;
        1: din = $urandom >> $urandom_range(31);
        2: din = m_hold;
        default: din = '0;
      endcase
      if ($urandom_range(49) == 0) blank_lz = ~blank_lz;
      cycle();
    end
    rst = 1'b0; upd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
